fpu_sched: RTL

Two-requester scheduler in front of the shared multi-cycle FPU. It arbitrates round-robin between two issue ports, latches the selected op and operands, and holds them stable on the FPU inputs until the FPU asserts fin. It then captures the result and returns it with the requester id and tag over a valid/ready response channel. Only one op is in flight at a time; this block is the sole driver of the FPU's src0/src1/fpuop.

---
 rtl/fpu_sched_if.sv | 55 +++++
 rtl/fpu_sched.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fpu_sched_if.sv
// fpu_sched_if: bundles the two issue ports, the response channel and the FPU-side
// signals of the fpu_sched scheduler.
// master = requesters, response consumer and FPU; slave = the scheduler itself.
interface fpu_sched_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [31:0]      req0_src0;
    logic [31:0]      req0_src1;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [31:0]      req1_src0;
    logic [31:0]      req1_src1;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_result;
    logic             rsp_err;

    logic [3:0]       fpu_op;
    logic [31:0]      fpu_src0;
    logic [31:0]      fpu_src1;
    logic [31:0]      fpu_result;
    logic             fpu_fin;

    modport master (
        output req0_valid, req0_op, req0_src0, req0_src1, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_src0, req1_src1, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_err,
        output rsp_ready,
        input  fpu_op, fpu_src0, fpu_src1,
        output fpu_result, fpu_fin
    );

    modport slave (
        input  req0_valid, req0_op, req0_src0, req0_src1, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_src0, req1_src1, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_err,
        input  rsp_ready,
        output fpu_op, fpu_src0, fpu_src1,
        input  fpu_result, fpu_fin
    );
endinterface

// File: rtl/fpu_sched.sv
// fpu_sched: two-requester round-robin scheduler in front of a shared multi-cycle FPU.
// One op is in flight at a time; its opcode and operands are held on the FPU inputs
// until fin, then the result is returned with requester id and tag on a valid/ready
// response channel.
// Optional feature macro: FPU_WATCHDOG_EN -- aborts an op whose fin has not arrived
// within TIMEOUT BUSY cycles, answering with result 0xFFFFFFFF and rsp_err=1.
module fpu_sched #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    fpu_sched_if.slave bus
);
    // Parking opcode: the FPU answers it with fin=1/result 0 and keeps its counter at 0.
    localparam logic [3:0] OP_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    if (TIMEOUT <= 11) begin : g_timeout_check
        $error("fpu_sched: TIMEOUT must exceed 11");
    end

    state_t           state;
    logic             rr;
    logic             grant_any;
    logic             grant_id;
    logic             accept;
    logic [3:0]       sel_op;
    logic [31:0]      sel_src0;
    logic [31:0]      sel_src1;
    logic [TAG_W-1:0] sel_tag;

    logic [3:0]       op_q;
    logic [31:0]      src0_q;
    logic [31:0]      src1_q;
    logic [TAG_W-1:0] tag_q;
    logic             id_q;

    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [31:0]      rsp_result_q;

`ifdef FPU_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0]  wd_cnt;
    logic             rsp_err_q;
`endif

    // Grant the lone valid requester, or the rr-selected one when both are valid.
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        grant_id  = (bus.req0_valid && bus.req1_valid) ? rr : bus.req1_valid;
        accept    = (state == IDLE) && grant_any;
        sel_op    = grant_id ? bus.req1_op   : bus.req0_op;
        sel_src0  = grant_id ? bus.req1_src0 : bus.req0_src0;
        sel_src1  = grant_id ? bus.req1_src1 : bus.req0_src1;
        sel_tag   = grant_id ? bus.req1_tag  : bus.req0_tag;
    end

    assign bus.req0_ready = accept && !grant_id;
    assign bus.req1_ready = accept &&  grant_id;

    // Scheduler FSM: accept in IDLE, wait for fin in BUSY, present the result in RESP.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            rr           <= 1'b0;
            op_q         <= OP_IDLE;
            src0_q       <= '0;
            src1_q       <= '0;
            tag_q        <= '0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rsp_result_q <= '0;
`ifdef FPU_WATCHDOG_EN
            wd_cnt       <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= sel_op;
                        src0_q <= sel_src0;
                        src1_q <= sel_src1;
                        tag_q  <= sel_tag;
                        id_q   <= grant_id;
                        rr     <= ~grant_id;
                        state  <= BUSY;
`ifdef FPU_WATCHDOG_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (bus.fpu_fin) begin
                        rsp_result_q <= bus.fpu_result;
                        rsp_id_q     <= id_q;
                        rsp_tag_q    <= tag_q;
                        rsp_valid_q  <= 1'b1;
                        op_q         <= OP_IDLE;
                        state        <= RESP;
`ifdef FPU_WATCHDOG_EN
                        rsp_err_q    <= 1'b0;
                    end else if (wd_cnt == WD_LAST) begin
                        rsp_result_q <= 32'hFFFF_FFFF;
                        rsp_id_q     <= id_q;
                        rsp_tag_q    <= tag_q;
                        rsp_err_q    <= 1'b1;
                        rsp_valid_q  <= 1'b1;
                        op_q         <= OP_IDLE;
                        wd_cnt       <= wd_cnt + 1'b1;
                        state        <= RESP;
                    end else begin
                        wd_cnt       <= wd_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.fpu_op     = op_q;
    assign bus.fpu_src0   = src0_q;
    assign bus.fpu_src1   = src1_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_tag    = rsp_tag_q;
    assign bus.rsp_result = rsp_result_q;
`ifdef FPU_WATCHDOG_EN
    assign bus.rsp_err    = rsp_err_q;
`else
    assign bus.rsp_err    = 1'b0;
`endif
endmodule
